// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared state encoding, framing constants and byte selection for the word UART link
package uart_link_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int FRAMES_PER_WORD = BYTES_PER_WORD + 1;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int DEF_CLKS_PER_BIT = 868;
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serialiser that can chain the next byte straight out of the last stop-bit cycle
module uart_byte_tx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       busy,
  output logic       done_pulse
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tick;
  logic          load;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign done_pulse = state == STOP && tick;
  // a start arriving on the final stop cycle reloads without an idle gap
  assign load = start && (state == IDLE || done_pulse);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else if (load) begin
      state   <= START;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= byte_in;
      tx      <= 1'b0;
      busy    <= 1'b1;
    end else if (state != IDLE) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        case (state)
          START: begin
            state <= DATA;
            tx    <= shift[0];
          end
          DATA:
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: rtl/word_uart_tx.sv
// word_uart_tx: sends each accepted 32-bit word as a sync byte plus four bytes, LSB first, 8N1
module word_uart_tx
  import uart_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  logic [31:0] word_q;
  logic [2:0]  byte_idx;
  logic        take;
  logic        last;
  logic        next;
  logic        byte_done;
  logic [7:0]  byte_in;
  assign word_ready = !busy;
  assign take = word_valid && word_ready;
  assign last = byte_idx == 3'(FRAMES_PER_WORD - 1);
  assign next = byte_done && !last;
  // byte_idx names the frame in flight; frame k>0 carries word byte k-1
  assign byte_in = take ? SYNC_BYTE : word_byte(word_q, byte_idx[1:0]);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word_q   <= '0;
      byte_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= byte_done && last;
      if (take) begin
        word_q   <= word_in;
        byte_idx <= '0;
      end else if (next) byte_idx <= byte_idx + 3'd1;
    end
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (take || next),
    .byte_in   (byte_in),
    .tx        (tx),
    .busy      (busy),
    .done_pulse(byte_done)
  );
endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: directed checks of framing, handshake, timing and reset for word_uart_tx
module tb_word_uart_tx;
  localparam int LOG = 8192;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] word4 = '0, word2 = '0;
  logic        valid4 = 1'b0, valid2 = 1'b0;
  logic        ready4, tx4, busy4, done4;
  logic        ready2, tx2, busy2, done2;
  logic        log4[0:LOG-1];
  logic        log2[0:LOG-1];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  word_uart_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst(rst), .word_in(word4), .word_valid(valid4),
    .word_ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
  );
  word_uart_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst(rst), .word_in(word2), .word_valid(valid2),
    .word_ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic o_tx(input int s);
    return s != 0 ? tx2 : tx4;
  endfunction
  function automatic logic o_busy(input int s);
    return s != 0 ? busy2 : busy4;
  endfunction
  function automatic logic o_done(input int s);
    return s != 0 ? done2 : done4;
  endfunction
  function automatic logic o_ready(input int s);
    return s != 0 ? ready2 : ready4;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc < LOG) begin
      log4[cyc] = tx4;
      log2[cyc] = tx2;
    end
  endtask

  // valid must already be driven; t becomes the log index of cycle 1 of the accepted word
  task automatic take(input int s, input logic clear, output int t);
    t = -1;
    for (int k = 0; k < 1000 && t < 0; k++) begin
      if (o_ready(s)) t = cyc + 1;
      tick();
    end
    if (clear) begin
      if (s != 0) valid2 = 1'b0;
      else valid4 = 1'b0;
    end
    if (t < 0) check("take_timeout", 0, 1);
  endtask

  task automatic decode(input int s, input int t, input int n, output logic [39:0] got, output int bad);
    int   idx;
    logic v, first;
    got = '0;
    bad = 0;
    first = 1'b0;
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < n; c++) begin
          idx = t + f * 10 * n + b * n + c;
          v = (idx >= 0 && idx < LOG) ? (s != 0 ? log2[idx] : log4[idx]) : 1'bx;
          if (c == 0) first = v;
          if (b == 0 && v !== 1'b0) bad++;
          else if (b == 9 && v !== 1'b1) bad++;
          else if (v !== first) bad++;
          if (b >= 1 && b <= 8 && c == 0) got[f*8+b-1] = v;
        end
  endtask

  task automatic single(input int s, input int n, input logic [31:0] w, input string tag);
    int          t, nb, nd, dcyc, bad;
    logic        rdy;
    logic [39:0] got;
    if (s != 0) begin
      word2 = w;
      valid2 = 1'b1;
    end else begin
      word4 = w;
      valid4 = 1'b1;
    end
    take(s, 1'b1, t);
    check({tag, "_latency"}, o_tx(s), 0);
    nb = int'(o_busy(s));
    nd = 0;
    dcyc = -1;
    rdy = 1'b0;
    for (int k = 2; k <= 50 * n + 2; k++) begin
      tick();
      nb += int'(o_busy(s));
      if (o_done(s)) begin
        nd++;
        if (dcyc < 0) dcyc = k;
      end
      if (k == 50 * n + 1) rdy = o_ready(s);
    end
    check({tag, "_busy_cycles"}, nb, 50 * n);
    check({tag, "_done_cycle"}, dcyc, 50 * n + 1);
    check({tag, "_done_count"}, nd, 1);
    check({tag, "_ready_at_done"}, rdy, 1);
    decode(s, t, n, got, bad);
    check({tag, "_bytes"}, got, {w, 8'hA5});
    check({tag, "_bit_timing"}, bad, 0);
  endtask

  initial begin
    int          t1, t2, bad, act;
    logic [39:0] got;
    repeat (3) tick();
    check("rst_tx", tx4, 1);
    check("rst_ready", ready4, 1);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_tx_n2", tx2, 1);
    rst = 1'b1;
    act = 0;
    repeat (100) begin
      tick();
      act += int'(!tx4 || busy4 || done4 || !ready4);
    end
    check("idle_quiet", act, 0);

    single(0, 4, 32'h12345678, "single");

    word4 = 32'hDEADBEEF;
    valid4 = 1'b1;
    take(0, 1'b1, t1);
    repeat (19) tick();
    word4 = 32'hCAFEF00D;
    valid4 = 1'b1;
    check("ignore_ready_low", ready4, 0);
    take(0, 1'b1, t2);
    check("ignore_accept_gap", t2 - t1, 201);
    repeat (200) tick();
    decode(0, t1, 4, got, bad);
    check("ignore_first_bytes", got, {32'hDEADBEEF, 8'hA5});
    check("ignore_first_timing", bad, 0);
    decode(0, t2, 4, got, bad);
    check("ignore_second_bytes", got, {32'hCAFEF00D, 8'hA5});
    check("ignore_second_timing", bad, 0);

    word4 = 32'h00000000;
    valid4 = 1'b1;
    take(0, 1'b0, t1);
    word4 = 32'hFFFFFFFF;
    take(0, 1'b1, t2);
    check("b2b_gap", t2 - t1, 201);
    check("b2b_idle_high", (t1 + 200 < LOG) ? log4[t1+200] : 1'bx, 1);
    repeat (200) tick();
    decode(0, t1, 4, got, bad);
    check("b2b_first_bytes", got, {32'h00000000, 8'hA5});
    check("b2b_first_timing", bad, 0);
    decode(0, t2, 4, got, bad);
    check("b2b_second_bytes", got, {32'hFFFFFFFF, 8'hA5});
    check("b2b_second_timing", bad, 0);

    word4 = 32'h11223344;
    valid4 = 1'b1;
    take(0, 1'b1, t1);
    repeat (56) tick();
    check("midrst_tx_before", tx4, 0);
    rst = 1'b0;
    #1;
    check("midrst_tx_async", tx4, 1);
    check("midrst_busy", busy4, 0);
    check("midrst_ready", ready4, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    single(0, 4, 32'h000000AA, "after_rst");

    single(1, 2, 32'h12345678, "n2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
